// File: rtl/pattern_detect_param.sv
// ---------------------------------------------------------------------------
// pattern_detect_param
//
// Serial pattern detector. It watches an MSB-first bit stream, qualified by
// data_valid, for a programmable and maskable W-bit pattern (W = 8*PAT_BYTES).
// The pattern must occur n times back-to-back. Each completed run produces a
// one-cycle data_flag pulse and bumps a saturating detection counter.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           detector enable; low returns the FSM to IDLE and flushes the
//                shift register
//   cont         1 = re-arm after a detection, 0 = hold DONE until en drops
//   n            required back-to-back repetitions (0 behaves as 1)
//   pattern      target pattern; bit W-1 is the first bit received
//   mask         1 = compare this bit, 0 = don't care
//   data         serial data bit
//   data_valid   data is sampled only while this is high
//   data_flag    registered one-cycle detection pulse
//   locked       high while part of a multi-copy run has been matched
//   rep_cnt      copies matched in the current run
//   match_count  total detections, saturating at all-ones
//
// pattern, mask, n and cont are expected to stay stable while en is high.
// ---------------------------------------------------------------------------
module pattern_detect_param #(
  parameter int PAT_BYTES = 4,
  parameter int CNT_W     = 3,
  parameter int MCNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cont,
  input  logic [CNT_W-1:0]       n,
  input  logic [8*PAT_BYTES-1:0] pattern,
  input  logic [8*PAT_BYTES-1:0] mask,
  input  logic                   data,
  input  logic                   data_valid,
  output logic                   data_flag,
  output logic                   locked,
  output logic [CNT_W-1:0]       rep_cnt,
  output logic [MCNT_W-1:0]      match_count
);

  localparam int W      = 8 * PAT_BYTES;
  localparam int FILL_W = $clog2(W + 1);
  localparam int GAP_W  = $clog2(W);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(W - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Registered state
  state_t              r_state;
  logic [W-1:0]        r_sr;
  logic [FILL_W-1:0]   r_fill;
  logic [GAP_W-1:0]    r_gap;
  logic [CNT_W-1:0]    r_rep_cnt;
  logic [MCNT_W-1:0]   r_match_count;
  logic                r_data_flag;
  logic                r_locked;

  // Combinational next-state values
  state_t              w_state_next;
  logic [W-1:0]        w_sr_next;
  logic [FILL_W-1:0]   w_fill_next;
  logic [GAP_W-1:0]    w_gap_next;
  logic [CNT_W-1:0]    w_rep_next;
  logic [MCNT_W-1:0]   w_mcnt_next;
  logic                w_flag_next;
  logic                w_detect;

  logic [W-1:0]        w_shifted;
  logic                w_hit;
  logic [CNT_W-1:0]    w_n_eff;
  logic [CNT_W-1:0]    w_rep_inc;
  logic                w_eval_hunt;

  // The comparison is made on the window as it will look after this bit is
  // shifted in, so a hit is recognised on the very edge that samples the
  // final bit of the pattern.
  assign w_shifted = {r_sr[W-2:0], data};
  assign w_hit     = data_valid && (r_fill >= FILL_ARM) &&
                     (((w_shifted ^ pattern) & mask) == '0);
  assign w_n_eff   = (n == '0) ? CNT_ONE : n;
  assign w_rep_inc = r_rep_cnt + CNT_ONE;

  // DONE with cont=1 behaves like HUNT for the bit sampled in that cycle, so a
  // new run (possibly overlapping the previous copy's tail) can start at once.
  assign w_eval_hunt = (r_state == ST_HUNT) || ((r_state == ST_DONE) && cont);

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_fill_next  = r_fill;
    w_gap_next   = r_gap;
    w_rep_next   = r_rep_cnt;
    w_mcnt_next  = r_match_count;
    w_flag_next  = 1'b0;
    w_detect     = 1'b0;

    if (!en) begin
      w_state_next = ST_IDLE;
      w_sr_next    = '0;
      w_fill_next  = '0;
      w_gap_next   = '0;
      w_rep_next   = '0;
    end else begin
      if (data_valid) begin
        w_sr_next = w_shifted;
        if (r_fill != FILL_FULL) begin
          w_fill_next = r_fill + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_HUNT;
        end
        ST_HUNT: begin
          // Run start is handled below together with the DONE re-arm case.
        end
        ST_LOCK: begin
          // Only the bit that completes an exactly adjacent copy is judged;
          // hits inside the current copy are ignored.
          if (data_valid) begin
            if (r_gap == GAP_LAST) begin
              if (w_hit) begin
                w_rep_next = w_rep_inc;
                if (w_rep_inc == w_n_eff) begin
                  w_detect = 1'b1;
                end else begin
                  w_gap_next = '0;
                end
              end else begin
                // Run broken: back to hunting without re-evaluating this bit.
                w_rep_next   = '0;
                w_state_next = ST_HUNT;
              end
            end else begin
              w_gap_next = r_gap + 1'b1;
            end
          end
        end
        ST_DONE: begin
          // cont=0 parks here until en drops; DONE with cont=1 always leaves
          // after one cycle, even if no valid bit arrives in it.
          if (cont) begin
            w_state_next = ST_HUNT;
            w_rep_next   = '0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase

      if (w_eval_hunt && w_hit) begin
        w_rep_next = CNT_ONE;
        if (w_n_eff == CNT_ONE) begin
          w_detect = 1'b1;
        end else begin
          w_state_next = ST_LOCK;
          w_gap_next   = '0;
        end
      end

      if (w_detect) begin
        w_state_next = ST_DONE;
        w_flag_next  = 1'b1;
        if (r_match_count != '1) begin
          w_mcnt_next = r_match_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_sr          <= '0;
      r_fill        <= '0;
      r_gap         <= '0;
      r_rep_cnt     <= '0;
      r_match_count <= '0;
      r_data_flag   <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_sr          <= w_sr_next;
      r_fill        <= w_fill_next;
      r_gap         <= w_gap_next;
      r_rep_cnt     <= w_rep_next;
      r_match_count <= w_mcnt_next;
      r_data_flag   <= w_flag_next;
      r_locked      <= (w_state_next == ST_LOCK);
    end
  end

  assign data_flag   = r_data_flag;
  assign locked      = r_locked;
  assign rep_cnt     = r_rep_cnt;
  assign match_count = r_match_count;

endmodule

// File: tb/tb_pattern_detect_param.sv
// ---------------------------------------------------------------------------
// Testbench for pattern_detect_param (PAT_BYTES=4, CNT_W=3, MCNT_W=4 so that
// counter saturation is reachable). A reference model tracks the stream as a
// window of recent bits and absolute bit positions of expected copy ends; it
// is compared with the DUT after every clock edge. Table vectors add fixed
// expectations for the main scenarios, followed by hand-written multi-cycle
// sequences and randomized rounds.
// ---------------------------------------------------------------------------
module tb_pattern_detect_param;

  localparam int W      = 32;
  localparam int MCNT_W = 4;
  localparam int MC_MAX = (1 << MCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              cont = 1'b0;
  logic [2:0]        n = 3'd1;
  logic [W-1:0]      pattern = '0;
  logic [W-1:0]      mask = '1;
  logic              data = 1'b0;
  logic              data_valid = 1'b0;
  logic              data_flag;
  logic              locked;
  logic [2:0]        rep_cnt;
  logic [MCNT_W-1:0] match_count;

  pattern_detect_param #(
    .PAT_BYTES(4),
    .CNT_W(3),
    .MCNT_W(MCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cont(cont),
    .n(n),
    .pattern(pattern),
    .mask(mask),
    .data(data),
    .data_valid(data_valid),
    .data_flag(data_flag),
    .locked(locked),
    .rep_cnt(rep_cnt),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 hunting, 2 inside a multi-copy run, 3 done
  bit   m_hist[$];
  int   m_k;
  int   m_mode;
  int   m_reps;
  int   m_next_end;
  int   m_mc;
  bit   m_flag;
  bit   m_locked;

  task automatic model_reset();
    m_hist.delete();
    m_k = 0; m_mode = 0; m_reps = 0; m_next_end = 0;
    m_mc = 0; m_flag = 0; m_locked = 0;
  endtask

  task automatic model_detect();
    m_mode = 3;
    m_flag = 1;
    if (m_mc < MC_MAX) m_mc++;
  endtask

  task automatic model_start(input int neff);
    m_reps = 1;
    if (neff == 1) model_detect();
    else begin
      m_mode = 2;
      m_next_end = m_k + W;
    end
  endtask

  task automatic model_step();
    bit hit;
    int neff;
    if (!rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      m_hist.delete();
      m_k = 0; m_mode = 0; m_reps = 0; m_flag = 0; m_locked = 0;
      return;
    end
    m_flag = 0;
    hit = 0;
    if (data_valid) begin
      m_hist.push_back(data);
      if (m_hist.size() > W) void'(m_hist.pop_front());
      m_k++;
      if (m_k >= W) begin
        hit = 1;
        for (int j = 0; j < W; j++)
          if (mask[W-1-j] && (m_hist[j] != pattern[W-1-j])) hit = 0;
      end
    end
    neff = (n == 0) ? 1 : int'(n);
    case (m_mode)
      0: m_mode = 1;
      1: if (hit) model_start(neff);
      2: if (data_valid && m_k == m_next_end) begin
           if (hit) begin
             m_reps++;
             if (m_reps == neff) model_detect();
             else m_next_end = m_k + W;
           end else begin
             m_reps = 0;
             m_mode = 1;
           end
         end
      default: if (cont) begin
           m_mode = 1;
           m_reps = 0;
           if (hit) model_start(neff);
         end
    endcase
    m_locked = (m_mode == 2);
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("data_flag", int'(data_flag), int'(m_flag));
    check_eq("locked", int'(locked), int'(m_locked));
    check_eq("rep_cnt", int'(rep_cnt), m_reps);
    check_eq("match_count", int'(match_count), m_mc);
  endtask

  int flags_seen;
  int last_flag;
  int bits_sent;
  bit lock_seen;

  task automatic clear_counters();
    flags_seen = 0; last_flag = 0; bits_sent = 0; lock_seen = 0;
  endtask

  // Drive one cycle, let the edge happen, then sample 1 time unit later.
  task automatic step(input logic v, input logic d);
    data_valid = v;
    data = d;
    @(posedge clk);
    model_step();
    #1;
    if (v) bits_sent++;
    check_all();
    if (data_flag === 1'b1) begin
      flags_seen++;
      last_flag = v ? bits_sent : -1;
    end
    if (locked === 1'b1) lock_seen = 1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int j = W - 1; j >= 0; j--) step(1'b1, w[j]);
  endtask

  task automatic prelude(input logic [2:0] nn, input logic cc,
                         input logic [W-1:0] pp, input logic [W-1:0] mm);
    rst = 1'b0;
    en = 1'b0;
    model_reset();
    step(1'b0, 1'b0);
    rst = 1'b1;
    n = nn; cont = cc; pattern = pp; mask = mm;
    en = 1'b1;
    step(1'b0, 1'b0);
    clear_counters();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [2:0]  n;
    logic        cont;
    logic [31:0] pat;
    logic [31:0] msk;
    logic [63:0] stream;
    int          len;
    int          gap_pct;
    int          exp_flags;
    int          exp_last;
    int          exp_mc;
    int          exp_lock_seen;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    bit q[$];
    logic [W-1:0] w;

    vecs[0] = '{3'd1, 1'b0, 32'hCCDDEEFF, 32'hFFFFFFFF, 64'hCCDDEEEFCCDDEEFF, 64, 0, 1, 64, 1, 0};
    vecs[1] = '{3'd2, 1'b0, 32'hCCDDEEFF, 32'hFFFFFFFF, 64'hCCDDEEFFCCDDEEFF, 64, 0, 1, 64, 1, 1};
    vecs[2] = '{3'd2, 1'b0, 32'hCCDDEEFF, 32'hFFFFFFFF, 64'hCCDDEEFFCCDDEEEF, 64, 0, 0, 0, 0, 1};
    vecs[3] = '{3'd1, 1'b1, 32'hAAAAAAAA, 32'hFFFFFFFF, 64'hAAAAAAAAAA000000, 40, 0, 5, 40, 5, 0};
    vecs[4] = '{3'd1, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, 64'hAAAAAAAAAA000000, 40, 0, 1, 32, 1, 0};
    vecs[5] = '{3'd1, 1'b0, 32'hCC00EEFF, 32'hFF00FFFF, 64'hCC12EEFF00000000, 32, 40, 1, 32, 1, 0};
    vecs[6] = '{3'd0, 1'b0, 32'hCC00EEFF, 32'hFF00FFFF, 64'hCC12EEFF00000000, 32, 40, 1, 32, 1, 0};

    // Reset state
    prelude(3'd1, 1'b0, 32'hCCDDEEFF, '1);
    check_eq("reset_flag", int'(data_flag), 0);
    check_eq("reset_locked", int'(locked), 0);
    check_eq("reset_rep_cnt", int'(rep_cnt), 0);
    check_eq("reset_match_count", int'(match_count), 0);

    foreach (vecs[i]) begin
      prelude(vecs[i].n, vecs[i].cont, vecs[i].pat, vecs[i].msk);
      for (int b = 0; b < vecs[i].len; b++) begin
        while ($urandom_range(0, 99) < vecs[i].gap_pct) step(1'b0, 1'($urandom));
        w = vecs[i].stream[63-b -: 1];
        step(1'b1, w[0]);
      end
      for (int t = 0; t < 3; t++) step(1'b0, 1'b0);
      check_eq($sformatf("vec%0d_flags", i), flags_seen, vecs[i].exp_flags);
      check_eq($sformatf("vec%0d_last_bit", i), last_flag, vecs[i].exp_last);
      check_eq($sformatf("vec%0d_match_count", i), int'(match_count), vecs[i].exp_mc);
      check_eq($sformatf("vec%0d_lock_seen", i), int'(lock_seen), vecs[i].exp_lock_seen);
      $display("vec %0d n=%0d cont=%0d flags=%0d last_bit=%0d match_count=%0d",
               i, vecs[i].n, vecs[i].cont, flags_seen, last_flag, match_count);
    end

    // Sequence A: asynchronous reset in the middle of an n=3 run
    prelude(3'd3, 1'b0, 32'hCCDDEEFF, '1);
    send_word(32'hCCDDEEFF);
    send_word(32'hCCDDEEFF);
    check_eq("A_locked_before", int'(locked), 1);
    check_eq("A_rep_before", int'(rep_cnt), 2);
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("A_async_locked", int'(locked), 0);
    check_eq("A_async_rep", int'(rep_cnt), 0);
    check_eq("A_async_flag", int'(data_flag), 0);
    step(1'b0, 1'b0);
    rst = 1'b1;
    clear_counters();
    send_word(32'hCCDDEEFF);
    step(1'b0, 1'b0);
    check_eq("A_third_flags", flags_seen, 0);
    check_eq("A_third_rep", int'(rep_cnt), 1);
    $display("seq A rep_cnt=%0d locked=%0d flags=%0d", rep_cnt, locked, flags_seen);

    // Sequence B: en drop keeps match_count, clears a partial run
    prelude(3'd1, 1'b0, 32'hCCDDEEFF, '1);
    send_word(32'hCCDDEEFF);
    step(1'b0, 1'b0);
    check_eq("B_mc_after_detect", int'(match_count), 1);
    en = 1'b0;
    step(1'b0, 1'b0);
    check_eq("B_mc_retained", int'(match_count), 1);
    n = 3'd2;
    en = 1'b1;
    step(1'b0, 1'b0);
    send_word(32'hCCDDEEFF);
    check_eq("B_locked", int'(locked), 1);
    en = 1'b0;
    step(1'b0, 1'b0);
    check_eq("B_locked_cleared", int'(locked), 0);
    check_eq("B_rep_cleared", int'(rep_cnt), 0);
    $display("seq B match_count=%0d locked=%0d", match_count, locked);

    // Sequence D: match_count saturation with overlapping detections
    prelude(3'd1, 1'b1, 32'hAAAAAAAA, '1);
    for (int b = 0; b < 80; b++) step(1'b1, 1'((b + 1) % 2));
    step(1'b0, 1'b0);
    check_eq("D_flags", flags_seen, 25);
    check_eq("D_saturated", int'(match_count), MC_MAX);
    $display("seq D flags=%0d match_count=%0d", flags_seen, match_count);

    // Randomized rounds against the model
    prelude(3'd1, 1'b0, 32'h0, '1);
    for (int r = 0; r < 30; r++) begin
      en = 1'b0;
      step(1'b0, 1'b0);
      n = 3'($urandom_range(0, 3));
      cont = 1'($urandom_range(0, 1));
      pattern = $urandom;
      for (int bb = 0; bb < 4; bb++)
        mask[8*bb +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 1) == 1) mask[$urandom_range(0, 31)] = 1'b0;
      en = 1'b1;
      clear_counters();
      q.delete();
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 9) < 7) begin
          w = pattern;
          if ($urandom_range(0, 6) == 0) w[$urandom_range(0, 31)] = ~w[$urandom_range(0, 31)];
          for (int j = W - 1; j >= 0; j--) q.push_back(w[j]);
        end else begin
          for (int j = $urandom_range(1, 40); j > 0; j--) q.push_back(1'($urandom));
        end
      end
      foreach (q[i]) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom));
        if ($urandom_range(0, 299) == 0) begin
          en = 1'b0;
          step(1'b0, 1'b0);
          en = 1'b1;
        end
        if ($urandom_range(0, 599) == 0) begin
          rst = 1'b0;
          model_reset();
          #1;
          check_eq("rand_async_reset_mc", int'(match_count), 0);
          step(1'b0, 1'b0);
          rst = 1'b1;
        end
        step(1'b1, q[i]);
      end
      step(1'b0, 1'b0);
      $display("round %0d n=%0d cont=%0d mask=%08h bits=%0d flags=%0d match_count=%0d",
               r, n, cont, mask, bits_sent, flags_seen, match_count);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
